// File: rtl/mips_sysmem_if.sv
// Core-side code/data bus plus console byte stream for mips_sysmem.
// master = core and console sink, slave = the memory/IO responder.
interface mips_sysmem_if;
    logic [31:0] PC;
    logic [31:0] op;
    logic [31:0] DA;
    logic        we;
    logic [31:0] DO;
    logic        re;
    logic [31:0] DI;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    modport master (
        output PC, DA, we, DO, re, tx_ready,
        input  op, DI, tx_data, tx_valid, irq
    );

    modport slave (
        input  PC, DA, we, DO, re, tx_ready,
        output op, DI, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/mips_sysmem.sv
// Word RAM plus I/O window (cycle counter, timer compare, console TX FIFO,
// sticky status) for the MIPS I core. Reads are combinational.
module mips_sysmem #(
    parameter int unsigned WORDS    = 4096,
    parameter logic [31:0] IO_BASE  = 32'hFFFF0000,
    parameter int unsigned TX_DEPTH = 4
) (
    input logic          clock,
    input logic          reset,
    mips_sysmem_if.slave bus
);
    localparam int unsigned AW = $clog2(WORDS);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [31:0] mem [WORDS];
    logic [7:0]  fifo_q [TX_DEPTH];

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q, match_d;
    logic        ovf_q, ovf_d;
    logic        fault_q, fault_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] occ_q, occ_d;

    logic        pc_ram, da_ram, da_io, da_unmapped;
    logic [1:0]  io_off;
    logic        empty, full, pop, push, push_ok;
    logic        wr_count, wr_compare, wr_status;
    logic [31:0] status, io_rdata;
    logic        unused_bits;

    assign unused_bits = ^{bus.DA[1:0], bus.PC[1:0]};

    always_comb begin
        pc_ram      = (bus.PC[31:AW+2] == '0);
        da_ram      = (bus.DA[31:AW+2] == '0);
        da_io       = (bus.DA[31:4] == IO_BASE[31:4]);
        da_unmapped = !da_ram && !da_io;
        io_off      = bus.DA[3:2];

        empty   = (occ_q == '0);
        full    = (occ_q == OW'(TX_DEPTH));
        pop     = !empty && bus.tx_ready;
        push    = bus.we && da_io && (io_off == 2'd3);
        // a full FIFO still accepts when the head leaves in the same cycle
        push_ok = push && (!full || pop);

        wr_count   = bus.we && da_io && (io_off == 2'd0);
        wr_compare = bus.we && da_io && (io_off == 2'd1);
        wr_status  = bus.we && da_io && (io_off == 2'd2);

        status = {27'b0, fault_q, ovf_q, empty, full, match_q};
        case (io_off)
            2'd0:    io_rdata = count_q;
            2'd1:    io_rdata = compare_q;
            2'd2:    io_rdata = status;
            default: io_rdata = '0;
        endcase
    end

    always_comb begin
        bus.op = pc_ram ? mem[bus.PC[AW+1:2]] : '0;
        bus.DI = '0;
        if (bus.re) begin
            if (da_ram)     bus.DI = mem[bus.DA[AW+1:2]];
            else if (da_io) bus.DI = io_rdata;
        end
        bus.tx_valid = !empty;
        bus.tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
        bus.irq      = match_q;
    end

    always_comb begin
        count_d   = wr_count ? bus.DO : count_q + 32'd1;
        compare_d = wr_compare ? bus.DO : compare_q;

        // sets are applied after clears so a coincident set wins
        match_d = match_q;
        if (wr_status && bus.DO[0]) match_d = 1'b0;
        if (count_q == compare_q)   match_d = 1'b1;

        ovf_d = ovf_q;
        if (wr_status && bus.DO[3]) ovf_d = 1'b0;
        if (push && !push_ok)       ovf_d = 1'b1;

        fault_d = fault_q;
        if (wr_status && bus.DO[4])               fault_d = 1'b0;
        if ((bus.re || bus.we) && da_unmapped)    fault_d = 1'b1;

        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        occ_d    = occ_q + OW'(push_ok) - OW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            fault_q   <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            fault_q   <= fault_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            occ_q     <= occ_d;
        end
    end

    // storage arrays carry no reset; RAM contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && push_ok) fifo_q[wr_ptr_q] <= bus.DO[7:0];
    end

    always_ff @(posedge clock) begin
        if (!reset && bus.we && da_ram) mem[bus.DA[AW+1:2]] <= bus.DO;
    end
endmodule

// File: tb/tb_mips_sysmem.sv
// Self-checking bench for mips_sysmem: directed scenarios plus randomized
// traffic compared against a queue/array reference model.
module tb_mips_sysmem;
    localparam int unsigned WORDS    = 4096;
    localparam logic [31:0] IO       = 32'hFFFF0000;
    localparam logic [27:0] IO_PAGE  = 28'hFFFF000;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] A_COUNT  = 32'hFFFF0000;
    localparam logic [31:0] A_CMP    = 32'hFFFF0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF0008;
    localparam logic [31:0] A_TX     = 32'hFFFF000C;

    logic clock = 1'b0;
    logic reset;
    mips_sysmem_if bus();

    mips_sysmem #(.WORDS(WORDS), .IO_BASE(IO), .TX_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    // reference model
    logic [31:0]  m_ram [int unsigned];
    logic [31:0]  m_count, m_compare;
    bit           m_match, m_ovf, m_fault;
    byte unsigned m_q [$];
    int tests = 0;
    int fails = 0;

    function automatic void model_update();
        bit          io  = (bus.DA[31:4] == IO_PAGE);
        bit          ram = (bus.DA < 4 * WORDS);
        logic [1:0]  off = bus.DA[3:2];
        bit          hit = (m_count == m_compare);
        if (reset) begin
            m_count = 0; m_compare = 32'hFFFFFFFF;
            m_match = 0; m_ovf = 0; m_fault = 0;
            m_q.delete();
            return;
        end
        if (bus.tx_ready && m_q.size() > 0) void'(m_q.pop_front());
        m_count = (bus.we && io && off == 2'd0) ? bus.DO : m_count + 32'd1;
        if (bus.we && io && off == 2'd1) m_compare = bus.DO;
        if (bus.we && io && off == 2'd2) begin
            if (bus.DO[0]) m_match = 0;
            if (bus.DO[3]) m_ovf = 0;
            if (bus.DO[4]) m_fault = 0;
        end
        if (hit) m_match = 1;
        if (bus.we && io && off == 2'd3) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.DO[7:0]);
            else m_ovf = 1;
        end
        if ((bus.re || bus.we) && !io && !ram) m_fault = 1;
        if (bus.we && ram) m_ram[bus.DA >> 2] = bus.DO;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a < 4 * WORDS) return m_ram.exists(a >> 2) ? m_ram[a >> 2] : 32'hx;
        if (a[31:4] == IO_PAGE) begin
            case (a[3:2])
                2'd0: return m_count;
                2'd1: return m_compare;
                2'd2: return {27'b0, m_fault, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), m_match};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_op(input logic [31:0] pc);
        return (pc < 4 * WORDS) ? exp_rd(pc) : 32'h0;
    endfunction

    task automatic drive(input logic [31:0] da, input bit w, input bit r, input logic [31:0] dout);
        bus.DA = da; bus.we = w; bus.re = r; bus.DO = dout;
    endtask

    task automatic tick();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.tx_ready = 1'b0; bus.PC = 32'h0;
        drive(32'h0, 0, 0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid got=%b exp=0", bus.tx_valid); end
        tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL rst_irq got=%b exp=0", bus.irq); end
        tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); end
        drive(A_COUNT, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h0) begin fails++; $display("FAIL rst_count got=%h exp=0", bus.DI); end
        tick();
        drive(A_CMP, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'hFFFFFFFF) begin fails++; $display("FAIL rst_compare got=%h exp=ffffffff", bus.DI); end
        tick();
        drive(A_STATUS, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h4) begin fails++; $display("FAIL rst_status got=%h exp=4", bus.DI); end
        tick();
    endtask

    task automatic test_ram();
        logic [31:0] e;
        for (int i = 0; i < 64; i++) begin
            drive(i * 4, 1, 0, $urandom); tick();
        end
        drive(32'h40, 1, 0, 32'hDEADBEEF); tick();
        drive(32'h40, 0, 1, 0); bus.PC = 32'h40; #1;
        tests++; if (bus.DI !== 32'hDEADBEEF) begin fails++; $display("FAIL ram_di got=%h exp=deadbeef", bus.DI); end
        tests++; if (bus.op !== 32'hDEADBEEF) begin fails++; $display("FAIL ram_op got=%h exp=deadbeef", bus.op); end
        bus.PC = 4 * WORDS; #1;
        tests++; if (bus.op !== 32'h0) begin fails++; $display("FAIL op_oob got=%h exp=0", bus.op); end
        // same-cycle read of a word being written returns the old value
        drive(32'h44, 1, 1, 32'h0BADF00D); #1;
        e = exp_rd(32'h44);
        tests++; if (bus.DI !== e) begin fails++; $display("FAIL rd_during_wr got=%h exp=%h", bus.DI, e); end
        tick();
        for (int i = 0; i < 64; i++) begin
            drive(i * 4 + (i % 4), 0, 1, 0); bus.PC = (63 - i) * 4; #1;
            e = exp_rd(i * 4);
            tests++; if (bus.DI !== e) begin fails++; $display("FAIL ram_rb[%0d] got=%h exp=%h", i, bus.DI, e); end
            e = exp_op((63 - i) * 4);
            tests++; if (bus.op !== e) begin fails++; $display("FAIL op_rb[%0d] got=%h exp=%h", i, bus.op, e); end
            tick();
        end
        bus.PC = 32'h0;
    endtask

    task automatic test_timer();
        drive(A_COUNT, 1, 0, 10); tick();
        drive(A_CMP, 1, 0, 13); tick();
        drive(A_STATUS, 1, 0, 1); tick();
        drive(32'h0, 0, 0, 0); tick();
        tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL irq_early got=%b exp=0", bus.irq); end
        tick();
        tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL irq_match got=%b exp=1", bus.irq); end
        drive(A_STATUS, 1, 0, 1); tick();
        tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL irq_clear got=%b exp=0", bus.irq); end
        drive(A_CMP, 1, 0, 20); tick();
        drive(A_COUNT, 1, 0, 18); tick();
        drive(32'h0, 0, 0, 0); tick(); tick();
        drive(A_STATUS, 1, 0, 1); tick();
        tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL irq_set_beats_clear got=%b exp=1", bus.irq); end
        drive(A_STATUS, 1, 0, 32'h19); tick();
        tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL irq_final_clear got=%b exp=0", bus.irq); end
    endtask

    task automatic test_fifo_fill_drain();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(A_TX, 1, 0, 32'h41 + i); tick();
        end
        drive(A_STATUS, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h02) begin fails++; $display("FAIL fifo_full_status got=%h exp=02", bus.DI); end
        drive(A_TX, 1, 0, 32'h45); tick();
        drive(A_STATUS, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h0A) begin fails++; $display("FAIL fifo_ovf_status got=%h exp=0a", bus.DI); end
        drive(32'h0, 0, 0, 0); bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'h41 + i))
                begin fails++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, 8'(8'h41 + i)); end
            tick();
        end
        drive(A_STATUS, 0, 1, 0); #1;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got=%b exp=0", bus.tx_valid); end
        tests++; if (bus.DI !== 32'h0C) begin fails++; $display("FAIL drain_status got=%h exp=0c", bus.DI); end
        tick();
        drive(A_STATUS, 1, 0, 32'h08); tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_fifo_push_pop();
        byte unsigned exp_seq [4] = '{8'h62, 8'h63, 8'h64, 8'h55};
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(A_TX, 1, 0, 32'h61 + i); tick();
        end
        bus.tx_ready = 1'b1;
        drive(A_TX, 1, 0, 32'h55); tick();
        for (int i = 0; i < 4; i++) begin
            drive(A_STATUS, 0, 1, 0); #1;
            if (i == 0) begin
                tests++; if (bus.DI !== 32'h02) begin fails++; $display("FAIL pushpop_status got=%h exp=02", bus.DI); end
            end
            tests++; if (bus.tx_data !== exp_seq[i]) begin fails++; $display("FAIL pushpop_seq[%0d] got=%h exp=%h", i, bus.tx_data, exp_seq[i]); end
            tick();
        end
        drive(A_TX, 1, 0, 32'h77); #1;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL empty_before got=%b exp=0", bus.tx_valid); end
        tick();
        drive(32'h0, 0, 0, 0); #1;
        tests++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77) begin fails++; $display("FAIL empty_push got=%b/%h exp=1/77", bus.tx_valid, bus.tx_data); end
        tick();
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL empty_after got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] e;
        drive(32'h80000000, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h0) begin fails++; $display("FAIL unmapped_rd got=%h exp=0", bus.DI); end
        tick();
        drive(A_STATUS, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h14) begin fails++; $display("FAIL fault_set got=%h exp=14", bus.DI); end
        tick();
        drive(32'h80000000, 1, 0, 32'hBADBAD00); tick();
        drive(32'h0, 0, 1, 0); #1;
        e = exp_rd(32'h0);
        tests++; if (bus.DI !== e) begin fails++; $display("FAIL unmapped_wr_ram got=%h exp=%h", bus.DI, e); end
        tick();
        drive(A_STATUS, 1, 0, 32'h10); tick();
        drive(A_STATUS, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'h04) begin fails++; $display("FAIL fault_clear got=%h exp=04", bus.DI); end
        tick();
    endtask

    task automatic test_reset_midflight();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(A_TX, 1, 0, 32'hA0 + i); tick();
        end
        drive(A_COUNT, 1, 0, 500); tick();
        drive(32'h40, 1, 0, 32'h12345678); bus.tx_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(A_COUNT, 0, 1, 0); #1;
        tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_flush got=%b exp=0", bus.tx_valid); end
        tests++; if (bus.DI !== 32'h0) begin fails++; $display("FAIL rst_mid_count got=%h exp=0", bus.DI); end
        tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL rst_mid_irq got=%b exp=0", bus.irq); end
        tick();
        drive(A_CMP, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'hFFFFFFFF) begin fails++; $display("FAIL rst_mid_compare got=%h exp=ffffffff", bus.DI); end
        tick();
        drive(32'h40, 0, 1, 0); #1;
        tests++; if (bus.DI !== 32'hDEADBEEF) begin fails++; $display("FAIL rst_ram_kept got=%h exp=deadbeef", bus.DI); end
        tick();
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] da, dout, e;
        int unsigned sel, idx;
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 99);
            idx = $urandom_range(0, 63);
            if (sel < 50)      da = idx * 4 + $urandom_range(0, 3);
            else if (sel < 90) da = IO + $urandom_range(0, 15);
            else               da = 32'h80000000 | ($urandom & 32'h3FFFFFFF);
            dout = $urandom;
            if (da[31:4] == IO_PAGE && da[3:2] == 2'd1) dout = m_count + $urandom_range(1, 6);
            if (da[31:4] == IO_PAGE && da[3:2] == 2'd0 && $urandom_range(0, 1) == 1) dout = m_compare - $urandom_range(1, 4);
            drive(da, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), dout);
            bus.tx_ready = ($urandom_range(0, 2) != 0);
            bus.PC = ($urandom_range(0, 3) == 0) ? (4 * WORDS + ($urandom & 32'h0FFFFFFC)) : ($urandom_range(0, 63) * 4);
            reset = ($urandom_range(0, 79) == 0);
            #1;
            e = bus.re ? exp_rd(bus.DA) : 32'h0;
            tests++; if (bus.DI !== e) begin fails++; $display("FAIL rnd_di[%0d] da=%h got=%h exp=%h", n, bus.DA, bus.DI, e); end
            e = exp_op(bus.PC);
            tests++; if (bus.op !== e) begin fails++; $display("FAIL rnd_op[%0d] pc=%h got=%h exp=%h", n, bus.PC, bus.op, e); end
            tests++; if (bus.tx_valid !== (m_q.size() != 0)) begin fails++; $display("FAIL rnd_tx_valid[%0d] got=%b exp=%b", n, bus.tx_valid, (m_q.size() != 0)); end
            if (m_q.size() != 0) begin
                tests++; if (bus.tx_data !== m_q[0]) begin fails++; $display("FAIL rnd_tx_data[%0d] got=%h exp=%h", n, bus.tx_data, m_q[0]); end
            end
            tests++; if (bus.irq !== m_match) begin fails++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", n, bus.irq, m_match); end
            tick();
        end
        reset = 1'b0;
        bus.tx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ram();
        test_timer();
        test_fifo_fill_drain();
        test_fifo_push_pop();
        test_unmapped();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
